serial_byte_receiver: RTL
=========================

// Module: serial_byte_receiver
// PURPOSE
//   Serial-to-parallel receiver. Accepts the LSB-first bit stream produced by the
//   team's right-shifting register (bit 0 shifts out first) and rebuilds it into
//   WIDTH-bit words.
//   A start strobe frames each word. A one-entry holding register with a valid/ready
//   handshake presents completed words to the consumer, and a sticky flag reports
//   words lost to overrun.
// PARAMETERS
//   WIDTH   8   bits per word (>=2)
//   CW      $clog2(WIDTH+1)   width of bit_count; derived, do not override
// PORTS
//   clock       in   1      single clock; all state changes on posedge
//   reset_n     in   1      synchronous, active-low reset
//   start       in   1      begin new frame (restart if one is in progress)
//   ser_in      in   1      serial data bit
//   ser_valid   in   1      ser_in is sampled this cycle (RECV state only)
//   data_ready  in   1      consumer accepts data_out this cycle
//   clear_ovr   in   1      clears overrun
//   data_out    out  WIDTH  received word; bit 0 = first bit received
//   data_valid  out  1      data_out holds an unconsumed word
//   busy        out  1      FSM is in RECV
//   bit_count   out  CW     bits received in the current frame
//   overrun     out  1      sticky: a completed word was dropped
// BEHAVIOUR
//   Reset (reset_n==0 at posedge):
//     state=IDLE; shift reg, data_out, bit_count=0; data_valid, overrun, busy=0.
//     Reset overrides every other input and aborts any frame in progress.
//   FSM states: IDLE, RECV.
//     IDLE: ser_valid is ignored. start=1 -> RECV, bit_count=0, shift reg=0.
//     RECV: start=1 -> restart: bit_count=0, partial word discarded, ser_valid
//       ignored that cycle (start has priority).
//     RECV: else ser_valid=1 -> shreg <= {ser_in, shreg[WIDTH-1:1]}; bit_count+1.
//     RECV: when the WIDTH-th bit is sampled -> word complete -> IDLE next cycle,
//       bit_count=0. The word is the shifted value including that bit.
//   Holding register / handshake:
//     Word complete and slot free (data_valid==0, or data_ready==1 this cycle):
//       data_out <= word, data_valid <= 1 the next cycle. Latency = 1 cycle after
//       the last bit.
//     data_valid && data_ready with no completion: data_valid <= 0; data_out keeps
//       its value.
//     Completion while data_valid && !data_ready: new word dropped, data_out
//       unchanged, overrun <= 1.
//     Completion with data_valid && data_ready in the same cycle: new word loaded,
//       data_valid stays 1, no overrun.
//     data_out is stable while data_valid==1 && data_ready==0.
//   overrun: set as above. clear_ovr=1 clears it. If set and clear coincide, set
//     wins (overrun stays 1).
//   busy = (state==RECV), registered with the state.
//   bit_count never exceeds WIDTH-1 when observed; no wrap beyond WIDTH.
//   ser_valid gaps of any length inside a frame are legal; the frame has no timeout.
// TESTING
//   1 reset: drive all inputs 0, reset_n=0 for 2 cycles -> all outputs 0, busy=0.
//   2 basic word: start, then 8 ser_valid bits 1,0,1,1,0,0,1,0 (LSB first) ->
//     data_out=8'h4D, data_valid=1 one cycle after the 8th bit; data_ready=1 ->
//     data_valid=0 next cycle.
//   3 gapped bits and restart: send 5 bits, assert start, then send 8'hA5 LSB-first
//     with idle gaps -> data_out=8'hA5, no residue from the first 5 bits.
//   4 overrun: receive 8'h11, hold data_ready=0, receive 8'h22 -> data_out stays
//     8'h11, overrun=1. clear_ovr -> overrun=0.
//   5 back-to-back: receive 8'h33, then 8'h44 with data_ready=1 on its completion
//     cycle -> data_out=8'h44, data_valid stays 1, overrun stays 0.
//   6 reset mid-frame: 4 bits in, reset_n=0 for 1 cycle -> busy=0, bit_count=0.
//     A following full frame of 8'hFF -> data_out=8'hFF.

Source files
------------

// File: rtl/serial_byte_receiver.sv
// rtl/serial_byte_receiver.sv - LSB-first serial to parallel receiver with one-entry output slot
module serial_byte_receiver #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             data_ready,
  input  logic             clear_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_count,
  output logic             overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_overrun;

  logic             w_frame_start;
  logic             w_sample;
  logic             w_complete;
  logic             w_slot_free;
  logic [WIDTH-1:0] w_word;

  // The shifted value including the bit sampled this cycle; bit 0 ends up as the first bit received.
  assign w_word      = {ser_in, r_shreg[WIDTH-1:1]};
  // The slot can take a new word if it is empty or its current word leaves this cycle.
  assign w_slot_free = !r_data_valid || data_ready;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle control strobes; start always wins over a sampled bit.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_sample      = 1'b0;
    w_complete    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_frame_start = 1'b1;
          w_state_nxt   = RECV;
        end
      end
      RECV: begin
        if (start) begin
          w_frame_start = 1'b1;
        end else if (ser_valid) begin
          w_sample = 1'b1;
          if (r_bit_count == LAST_BIT) begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register and bit counter for the frame being assembled.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_shreg     <= '0;
      r_bit_count <= '0;
    end else if (w_frame_start) begin
      r_shreg     <= '0;
      r_bit_count <= '0;
    end else if (w_sample) begin
      r_shreg     <= w_word;
      r_bit_count <= w_complete ? '0 : r_bit_count + CW'(1);
    end
  end

  // One-entry holding register with valid/ready handshake.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else if (w_complete && w_slot_free) begin
      r_data_out   <= w_word;
      r_data_valid <= 1'b1;
    end else if (!w_complete && r_data_valid && data_ready) begin
      r_data_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_complete && !w_slot_free) begin
      r_overrun <= 1'b1;
    end else if (clear_ovr) begin
      r_overrun <= 1'b0;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign busy       = (r_state == RECV);
  assign bit_count  = r_bit_count;
  assign overrun    = r_overrun;

endmodule
